aes_spi_ctrl: RTL

Transaction controller between the SPI slave and the AES core. It tracks SPI frames on `cs` and accepts a load frame of message plus key. It then latches the operands and launches one AES operation, captures the result, and releases it for the following SPI output frame. It also flags malformed frames, protocol collisions and core timeouts.

---
 rtl/aes_spi_ctrl_if.sv | 29 ++
 rtl/aes_spi_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/aes_spi_ctrl_if.sv
// Bundle between the SPI-side transaction controller, the SPI slave and the AES core.
// slave = controller view; master = the surrounding SPI slave / core / test environment.
interface aes_spi_ctrl_if #(
  parameter int Nk = 4
);
  logic                 cs;
  logic [127:0]         msg_in;
  logic [Nk*32-1:0]     key_in;
  logic [127:0]         aes_result;
  logic                 aes_done;
  logic [127:0]         aes_msg;
  logic [Nk*32-1:0]     aes_key;
  logic                 aes_start;
  logic [127:0]         processed_out;
  logic                 busy;
  logic                 result_valid;
  logic                 err;
  logic [1:0]           err_code;

  modport slave (
    input  cs, msg_in, key_in, aes_result, aes_done,
    output aes_msg, aes_key, aes_start, processed_out, busy, result_valid, err, err_code
  );

  modport master (
    output cs, msg_in, key_in, aes_result, aes_done,
    input  aes_msg, aes_key, aes_start, processed_out, busy, result_valid, err, err_code
  );
endinterface

// File: rtl/aes_spi_ctrl.sv
// SPI frame tracker / AES launch controller: load frame -> one AES op -> result held for readout.
// Start one cycle after load cs fall, result one cycle after aes_done; no backpressure, frames during an op are flagged and dropped.
module aes_spi_ctrl #(
  parameter int Nk      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  aes_spi_ctrl_if.slave bus
);
  localparam int L  = 128 + Nk*32;
  localparam int KW = Nk*32;
  localparam int BW = $clog2(L+2);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, READY, SEND} state_t;

  state_t          state, state_d;
  logic            cs_q;
  logic [BW-1:0]   bitcnt;
  logic [TW-1:0]   tcnt;
  logic            cs_rise, cs_fall;
  logic            load_op, capture, err_set;
  logic [1:0]      err_code_d;

  logic [127:0]    aes_msg_q, processed_q;
  logic [KW-1:0]   aes_key_q;
  logic            aes_start_q, busy_q, result_valid_q, err_q;
  logic [1:0]      err_code_q;

  assign cs_rise = bus.cs & ~cs_q;
  assign cs_fall = ~bus.cs & cs_q;

  always_comb begin
    state_d    = state;
    load_op    = 1'b0;
    capture    = 1'b0;
    err_set    = 1'b0;
    err_code_d = 2'd0;
    case (state)
      IDLE:  if (cs_rise) state_d = LOAD;
      LOAD: begin
        if (cs_fall) begin
          if (bitcnt == BW'(L)) begin
            load_op = 1'b1;
            state_d = START;
          end else begin
            err_set    = 1'b1;
            err_code_d = 2'd1;
            state_d    = IDLE;
          end
        end
      end
      START: begin
        state_d = BUSY;
        if (cs_rise) begin
          err_set    = 1'b1;
          err_code_d = 2'd2;
        end
      end
      BUSY: begin
        if (cs_rise) begin
          err_set    = 1'b1;
          err_code_d = 2'd2;
        end
        // Completion beats a timeout that expires on the same edge.
        if (bus.aes_done) begin
          capture = 1'b1;
          state_d = READY;
        end else if (tcnt == TW'(TIMEOUT)) begin
          err_set    = 1'b1;
          err_code_d = 2'd3;
          state_d    = IDLE;
        end
      end
      READY: if (cs_rise) state_d = SEND;
      SEND:  if (cs_fall) state_d = (bitcnt >= BW'(128)) ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cs_q           <= 1'b0;
      bitcnt         <= '0;
      tcnt           <= '0;
      aes_msg_q      <= '0;
      aes_key_q      <= '0;
      processed_q    <= '0;
      aes_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      state <= state_d;
      cs_q  <= bus.cs;

      // The rising-edge cycle already carries the first bit, so a frame of n cycles ends at n.
      if (cs_rise)
        bitcnt <= BW'(1);
      else if (bus.cs && bitcnt != BW'(L+1))
        bitcnt <= bitcnt + BW'(1);

      if (state_d == START)
        tcnt <= '0;
      else if (state_d == BUSY)
        tcnt <= tcnt + TW'(1);

      if (load_op) begin
        aes_msg_q <= bus.msg_in;
        aes_key_q <= bus.key_in;
      end
      if (capture)
        processed_q <= bus.aes_result;

      aes_start_q    <= (state_d == START);
      busy_q         <= (state_d == START) || (state_d == BUSY);
      result_valid_q <= (state_d == READY) || (state_d == SEND);

      if (load_op) begin
        err_q      <= 1'b0;
        err_code_q <= 2'd0;
      end else if (err_set) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_d;
      end
    end
  end

  assign bus.aes_msg       = aes_msg_q;
  assign bus.aes_key       = aes_key_q;
  assign bus.processed_out = processed_q;
  assign bus.aes_start     = aes_start_q;
  assign bus.busy          = busy_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.err           = err_q;
  assign bus.err_code      = err_code_q;
endmodule
